// File: rtl/qsys_system_onchip_ram.sv
// rtl/qsys_system_onchip_ram.sv - Avalon-MM on-chip RAM with byte enables, clear sweep and read pipeline
module qsys_system_onchip_ram #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 12,
    parameter int                    DEPTH          = 4096,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic                    clken,
    input  logic                    freeze,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic                    init_done
);

    localparam int                    LP_LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE_RST = 2'd0,
        CLEAR    = 2'd1,
        READY    = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_addr;
    logic                    w_clr_last;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_in_range;
    logic                    w_rd_acc;
    logic                    w_wr_acc;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;
    logic [LP_LANES-1:0]     w_mem_be;

    logic                    w_out_vld;
    logic [DATA_WIDTH-1:0]   w_out_data;
    logic                    r_rdv;
    logic [DATA_WIDTH-1:0]   r_readdata;

    // Host-visible status: commands stall until the sweep is done and whenever the clock is gated.
    assign waitrequest = (r_state != READY) | ~clken;
    assign init_done   = (r_state == READY);

    // Command decode; a simultaneous read+write is treated as a write only.
    assign w_in_range = ({1'b0, address} < LP_DEPTH);
    assign w_wr_acc   = chipselect & write & ~waitrequest;
    assign w_rd_acc   = chipselect & read & ~write & ~waitrequest;
    assign w_rd_word  = w_in_range ? r_mem[address] : '0;
    assign w_clr_last = (r_clr_addr == LP_LAST);

    // Next-state logic for the reset / clear / ready sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE_RST: w_state_nxt = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            CLEAR:    if (w_clr_last) w_state_nxt = READY;
            READY:    w_state_nxt = READY;
            default:  w_state_nxt = IDLE_RST;
        endcase
    end

    // State register; frozen while the clock enable is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE_RST;
        end else if (clken) begin
            r_state <= w_state_nxt;
        end
    end

    // Clear sweep address counter, advanced once per enabled cycle in CLEAR.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clr_addr <= '0;
        end else if (clken && (r_state == CLEAR)) begin
            r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    // Single write port shared by the clear sweep and host writes (sweep owns it while clearing).
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = address;
        w_mem_wdata = writedata;
        w_mem_be    = byteenable;
        if (r_state == CLEAR) begin
            w_mem_we    = reset_n & clken;
            w_mem_addr  = r_clr_addr;
            w_mem_wdata = CLEAR_VALUE;
            w_mem_be    = '1;
        end else if (w_wr_acc && !freeze && w_in_range) begin
            w_mem_we    = reset_n;
        end
    end

    // Byte-lane masked array write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < LP_LANES; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_addr][8*b +: 8] <= w_mem_wdata[8*b +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY >= 2) begin : g_lat2
            logic                  r_p1_vld;
            logic [DATA_WIDTH-1:0] r_p1_data;

            // Extra pipeline stage between the array read and the output register.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_p1_vld  <= 1'b0;
                    r_p1_data <= '0;
                end else if (clken) begin
                    r_p1_vld <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_p1_data <= w_rd_word;
                    end
                end
            end

            assign w_out_vld  = r_p1_vld;
            assign w_out_data = r_p1_data;
        end else begin : g_lat1
            assign w_out_vld  = w_rd_acc;
            assign w_out_data = w_rd_word;
        end
    endgenerate

    // Output register: readdata only moves on a response so it holds the last returned word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdv      <= 1'b0;
            r_readdata <= '0;
        end else if (clken) begin
            r_rdv <= w_out_vld;
            if (w_out_vld) begin
                r_readdata <= w_out_data;
            end
        end
    end

    // A response held over a gated cycle is presented once the enable returns.
    assign readdatavalid = r_rdv & clken;
    assign readdata      = r_readdata;

endmodule

// File: doc/qsys_system_onchip_ram.md
QSYS_SYSTEM_ONCHIP_RAM -- requirements
Module: qsys_system_onchip_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; a multiple of 8, range 8..128.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, word-address width.
REQ-003 SHALL have parameter DEPTH, default 4096, number of words; DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1, cycles from read acceptance to data; legal values 1 or 2.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1, which enables the post-reset memory clear sweep.
REQ-006 SHALL have parameter CLEAR_VALUE, default 0, the word written by the clear sweep.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-008 SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-009 SHALL have port address, input, ADDR_WIDTH bits: word address.
REQ-010 SHALL have port byteenable, input, DATA_WIDTH/8 bits: write byte lanes.
REQ-011 SHALL have ports chipselect, read and write, each input, 1 bit: Avalon-MM slave command qualifiers.
REQ-012 SHALL have port writedata, input, DATA_WIDTH bits.
REQ-013 SHALL have port clken, input, 1 bit: global clock enable.
REQ-014 SHALL have port freeze, input, 1 bit: write-protect.
REQ-015 SHALL have port readdata, output, DATA_WIDTH bits, registered.
REQ-016 SHALL have port readdatavalid, output, 1 bit: one-cycle pulse per read response.
REQ-017 SHALL have port waitrequest, output, 1 bit: command not accepted this cycle.
REQ-018 SHALL have port init_done, output, 1 bit: high once the clear sweep is complete.

Function
REQ-019 SHALL implement a 3-state FSM with states IDLE_RST, CLEAR and READY.
  - IDLE_RST is the reset state; the next cycle goes to CLEAR if CLEAR_ON_RESET=1, else to READY.
REQ-020 In CLEAR, each cycle with clken=1 SHALL write CLEAR_VALUE (all lanes) to clr_addr, then increment clr_addr.
  - After writing DEPTH-1, the FSM goes to READY.
  - A 4096-word clear therefore takes 4096 enabled cycles.
REQ-021 waitrequest SHALL equal (state != READY) | ~clken; init_done SHALL be 1 only in READY.
REQ-022 A command SHALL be accepted only when chipselect=1 & (read|write)=1 & waitrequest=0.
REQ-023 For an accepted write with freeze=0, SHALL update only the bytes whose byteenable bit is 1; with freeze=1 the write is accepted and discarded.
REQ-024 When read=1 and write=1 together, SHALL perform the write only and generate no read response.
REQ-025 An accepted read SHALL produce readdatavalid=1 with data exactly READ_LATENCY cycles later.
  - Back-to-back reads SHALL be sustained at one per cycle with responses in order.
REQ-026 A read accepted the cycle after a write to the same address SHALL return the newly written data (new-data read-after-write).
REQ-027 An address >= DEPTH SHALL ignore writes and return all-zero read data, still with readdatavalid.
REQ-028 While clken=0, SHALL freeze all state, the read pipeline and the clear counter; readdatavalid is 0 and readdata holds its value.
REQ-029 readdata SHALL hold the last returned value whenever readdatavalid=0.
REQ-030 freeze SHALL have no effect on reads or on the clear sweep.

Reset
REQ-031 On reset_n=0 at a clock edge, SHALL set the following:
  - state to IDLE_RST and clr_addr to 0;
  - readdata to 0, readdatavalid to 0, waitrequest to 1, init_done to 0;
  - discard all in-flight read responses.
REQ-032 Memory contents SHALL NOT be reset directly; with CLEAR_ON_RESET=0 they persist across reset.
REQ-033 A reset asserted during CLEAR SHALL restart the sweep from address 0.

Verification
REQ-034 Reset, then 4096 cycles with clken=1 -> waitrequest=1 for the whole sweep and init_done rises on the next cycle; a read of address 0xFFF returns 0x00000000.
REQ-035 With READ_LATENCY=2: write 0xDEADBEEF to address 5, then read 5 on the next cycle -> readdatavalid pulses 2 cycles after read acceptance with readdata=0xDEADBEEF.
REQ-036 Write 0x11223344 with byteenable=4'b0101 over 0xAAAAAAAA -> read returns 0xAA22AA44; repeat with freeze=1 and data 0 -> contents unchanged.
REQ-037 Issue 4 back-to-back reads to addresses 0..3 with clken dropped for 2 cycles mid-stream -> exactly 4 in-order responses, none while clken=0.
REQ-038 Assert reset_n=0 at clr_addr=100, then release -> the sweep restarts from 0 and init_done rises only after a full 4096 enabled cycles; all pending read responses are dropped.
REQ-039 With DEPTH=3000 and ADDR_WIDTH=12, write to address 3500, then read address 3500 -> readdata=0, and no array location is modified.
